big_alu: RTL and testbench



---
 rtl/big_alu.sv | 113 +++++++++++
 tb/tb_big_alu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/big_alu.sv
// -----------------------------------------------------------------------------
// big_alu
//
// Registered signed-magnitude adder/subtractor for the mantissa datapath of an
// IEEE-754 add/sub pipeline. It sits between exponent alignment and the
// normaliser. Operands are unsigned magnitudes with separate sign bits. The
// result magnitude is one bit wider than the operands, so the carry-out of a
// magnitude add is kept in out[DATA_WIDTH].
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   a, b, sign_a, sign_b and symbol are valid this cycle
//   a, b       operand magnitudes, unsigned, DATA_WIDTH bits
//   sign_a     sign of A (1 = negative)
//   sign_b     sign of B (1 = negative)
//   symbol     operation: 0 = A + B, 1 = A - B
//   out        result magnitude, DATA_WIDTH+1 bits, MSB is the carry
//   sign_out   result sign
//   out_valid  out/sign_out hold a new result this cycle (one cycle latency)
// -----------------------------------------------------------------------------
module big_alu #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sign_a,
    input  logic                  sign_b,
    input  logic                  symbol,
    output logic [DATA_WIDTH:0]   out,
    output logic                  sign_out,
    output logic                  out_valid
);

    // Operands zero-extended by one bit so the add keeps its carry.
    logic [DATA_WIDTH:0] a_ext;
    logic [DATA_WIDTH:0] b_ext;
    logic                eff_sign_b;
    logic                mag_add;
    logic                a_ge_b;
    logic [DATA_WIDTH:0] res_mag;
    logic                res_sign;

    logic [DATA_WIDTH:0] out_d;
    logic [DATA_WIDTH:0] out_q;
    logic                sign_out_d;
    logic                sign_out_q;
    logic                out_valid_d;
    logic                out_valid_q;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    // Subtracting B is adding B with its sign flipped.
    assign eff_sign_b = sign_b ^ symbol;
    assign mag_add    = (sign_a == eff_sign_b);
    assign a_ge_b     = (a >= b);

    always_comb begin
        // NOTE: every signal gets a default at the top of the block so no
        // path through the ifs can leave it unassigned and infer a latch.
        res_mag  = '0;
        res_sign = 1'b0;
        if (mag_add) begin
            res_mag  = a_ext + b_ext;
            res_sign = sign_a;
        end else if (a_ge_b) begin
            res_mag  = a_ext - b_ext;
            res_sign = sign_a;
        end else begin
            res_mag  = b_ext - a_ext;
            res_sign = eff_sign_b;
        end
        // A zero magnitude is always reported as +0, never -0.
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    // Result registers load only on an accepted operation and hold otherwise.
    always_comb begin
        out_d       = out_q;
        sign_out_d  = sign_out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d      = res_mag;
            sign_out_d = res_sign;
        end
    end

    // Reset wins over in_valid, so an operation presented during rst is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            out_q       <= '0;
            sign_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            sign_out_q  <= sign_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign sign_out  = sign_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_big_alu.sv
// -----------------------------------------------------------------------------
// tb_big_alu
//
// Directed testbench for big_alu with DATA_WIDTH = 24. Inputs are driven 1 ns
// after a rising edge and outputs are sampled 1 ns after the next rising edge.
// Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_big_alu;

    localparam int DW = 24;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sa;
        logic          sb;
        logic          sym;
        logic [DW:0]   exp_out;
        logic          exp_sign;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sign_a;
    logic          sign_b;
    logic          symbol;
    logic [DW:0]   out;
    logic          sign_out;
    logic          out_valid;

    int vectors;
    int miscompares;

    big_alu #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .symbol    (symbol),
        .out       (out),
        .sign_out  (sign_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one valid operation and step to just after the capturing edge.
    task automatic send(input vec_t v);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        sign_a   = v.sa;
        sign_b   = v.sb;
        symbol   = v.sym;
        @(posedge clk);
        #1;
    endtask

    // Drop in_valid with scrambled operand values for n cycles.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            a        = 24'hABCDEF + DW'(i);
            b        = 24'h123456;
            sign_a   = 1'b1;
            sign_b   = 1'b0;
            symbol   = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        a = 24'd7; b = 24'd9; sign_a = 1'b1; sign_b = 1'b0; symbol = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out !== '0 || sign_out !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: out=%0d sign=%0b valid=%0b, expected out=0 sign=0 valid=0",
                     out, sign_out, out_valid);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        vec_t tbl[4];
        tbl = '{
            '{24'd100,      24'd215,      1'b0, 1'b0, 1'b0, 25'd315,      1'b0},
            '{24'd16777210, 24'd20,       1'b0, 1'b0, 1'b0, 25'd16777230, 1'b0},
            '{24'd100,      24'd16777210, 1'b0, 1'b1, 1'b1, 25'd16777310, 1'b0},
            '{24'd100,      24'd16777210, 1'b1, 1'b1, 1'b0, 25'd16777310, 1'b1}
        };
        for (int i = 0; i < 4; i++) begin
            send(tbl[i]);
            vectors++;
            if (out !== tbl[i].exp_out || sign_out !== tbl[i].exp_sign || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL add[%0d]: out=%0d sign=%0b valid=%0b, expected out=%0d sign=%0b valid=1",
                         i, out, sign_out, out_valid, tbl[i].exp_out, tbl[i].exp_sign);
            end
        end
        idle(1);
    endtask

    task automatic test_subtract();
        vec_t tbl[5];
        tbl = '{
            '{24'd215, 24'd100, 1'b0, 1'b1, 1'b0, 25'd115, 1'b0},
            '{24'd85,  24'd215, 1'b0, 1'b1, 1'b0, 25'd130, 1'b1},
            '{24'd126, 24'd215, 1'b0, 1'b0, 1'b1, 25'd89,  1'b1},
            '{24'd215, 24'd100, 1'b1, 1'b0, 1'b0, 25'd115, 1'b1},
            '{24'd126, 24'd215, 1'b1, 1'b1, 1'b1, 25'd89,  1'b0}
        };
        for (int i = 0; i < 5; i++) begin
            send(tbl[i]);
            vectors++;
            if (out !== tbl[i].exp_out || sign_out !== tbl[i].exp_sign || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL subtract[%0d]: out=%0d sign=%0b valid=%0b, expected out=%0d sign=%0b valid=1",
                         i, out, sign_out, out_valid, tbl[i].exp_out, tbl[i].exp_sign);
            end
        end
        idle(1);
    endtask

    task automatic test_zero_hold();
        vec_t v;
        // Negative result first so the zero's +0 sign is distinguishable.
        v = '{24'd85, 24'd215, 1'b0, 1'b1, 1'b0, 25'd130, 1'b1};
        send(v);
        v = '{24'd500, 24'd500, 1'b0, 1'b1, 1'b0, 25'd0, 1'b0};
        send(v);
        vectors++;
        if (out !== 25'd0 || sign_out !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_result: out=%0d sign=%0b valid=%0b, expected out=0 sign=0 valid=1",
                     out, sign_out, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            vectors++;
            if (out !== 25'd0 || sign_out !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_hold[%0d]: out=%0d sign=%0b valid=%0b, expected out=0 sign=0 valid=0",
                         i, out, sign_out, out_valid);
            end
        end
        // Hold of a nonzero negative carry result.
        v = '{24'd100, 24'd16777210, 1'b1, 1'b1, 1'b0, 25'd16777310, 1'b1};
        send(v);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            vectors++;
            if (out !== 25'd16777310 || sign_out !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL nonzero_hold[%0d]: out=%0d sign=%0b valid=%0b, expected out=16777310 sign=1 valid=0",
                         i, out, sign_out, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t tbl[4];
        tbl = '{
            '{24'd1,        24'd2,        1'b0, 1'b0, 1'b1, 25'd1,        1'b1},
            '{24'hFFFFFF,   24'hFFFFFF,   1'b0, 1'b0, 1'b0, 25'h1FFFFFE,  1'b0},
            '{24'd0,        24'hFFFFFF,   1'b1, 1'b0, 1'b1, 25'hFFFFFF,   1'b1},
            '{24'd1000,     24'd1,        1'b1, 1'b1, 1'b0, 25'd1001,     1'b1}
        };
        for (int i = 0; i < 4; i++) begin
            send(tbl[i]);
            vectors++;
            if (out !== tbl[i].exp_out || sign_out !== tbl[i].exp_sign || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: out=%0d sign=%0b valid=%0b, expected out=%0d sign=%0b valid=1",
                         i, out, sign_out, out_valid, tbl[i].exp_out, tbl[i].exp_sign);
            end
        end
        idle(1);
        vectors++;
        if (out_valid !== 1'b0 || out !== 25'd1001) begin
            miscompares++;
            $display("FAIL back_to_back_end: out=%0d valid=%0b, expected out=1001 valid=0",
                     out, out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        vec_t v;
        v = '{24'd215, 24'd100, 1'b1, 1'b0, 1'b0, 25'd115, 1'b1};
        send(v);
        vectors++;
        if (out !== 25'd115 || sign_out !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_op: out=%0d sign=%0b valid=%0b, expected out=115 sign=1 valid=1",
                     out, sign_out, out_valid);
        end
        // Operation presented while rst is high must be discarded.
        rst = 1'b1;
        v = '{24'd300, 24'd400, 1'b1, 1'b1, 1'b0, 25'd700, 1'b1};
        send(v);
        rst = 1'b0;
        vectors++;
        if (out !== 25'd0 || sign_out !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_stream: out=%0d sign=%0b valid=%0b, expected out=0 sign=0 valid=0",
                     out, sign_out, out_valid);
        end
        idle(1);
        vectors++;
        if (out !== 25'd0 || sign_out !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_discard: out=%0d sign=%0b valid=%0b, expected out=0 sign=0 valid=0",
                     out, sign_out, out_valid);
        end
        v = '{24'd126, 24'd215, 1'b0, 1'b0, 1'b1, 25'd89, 1'b1};
        send(v);
        vectors++;
        if (out !== 25'd89 || sign_out !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_op: out=%0d sign=%0b valid=%0b, expected out=89 sign=1 valid=1",
                     out, sign_out, out_valid);
        end
        idle(1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        sign_a      = 1'b0;
        sign_b      = 1'b0;
        symbol      = 1'b0;

        test_reset();
        test_add();
        test_subtract();
        test_zero_hold();
        test_back_to_back();
        test_reset_mid_stream();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
